// File: rtl/mips_pkg.sv
// Shared MIPS control encodings: sequencer states, opcodes,
// ALU/mux select codes and the per-cycle control word.
package mips_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_RWB     = 4'd7,
      S_BRANCH  = 4'd8,
      S_JUMP    = 4'd9,
      S_ADDI_EX = 4'd10,
      S_ADDI_WB = 4'd11,
      S_INT     = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_ONE  = 2'b01;
   localparam logic [1:0] SRCB_SIMM = 2'b10;
   localparam logic [1:0] SRCB_BTGT = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;
   localparam logic [1:0] PC_VEC    = 2'b11;

   // pc_write_cond marks the branch state: pcWrite follows zero there
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       epc_write;
      logic       iord;
      logic       reg_dst;
      logic       memto_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Moore decode of the sequencer state into the raw datapath
// control word (strobes ungated).
module mc_output_decode
   import mips_pkg::*;
(
   input  state_t state,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      unique case (1'b1)
         (state == S_FETCH): begin
            ctrl.mem_read  = 1'b1;
            ctrl.ir_write  = 1'b1;
            ctrl.pc_write  = 1'b1;
            ctrl.alu_src_b = SRCB_ONE;
         end
         (state == S_DECODE): begin
            ctrl.alu_src_b = SRCB_BTGT;
         end
         (state == S_MEMADR),
         (state == S_ADDI_EX): begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_SIMM;
         end
         (state == S_MEMRD): begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         (state == S_MEMWB): begin
            ctrl.reg_write = 1'b1;
            ctrl.memto_reg = 1'b1;
         end
         (state == S_MEMWR): begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
         end
         (state == S_EXEC): begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALU_FUNCT;
         end
         (state == S_RWB): begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         (state == S_BRANCH): begin
            ctrl.pc_write_cond = 1'b1;
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_op        = ALU_SUB;
            ctrl.pc_source     = PC_ALUOUT;
         end
         (state == S_JUMP): begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PC_JUMP;
         end
         (state == S_ADDI_WB): begin
            ctrl.reg_write = 1'b1;
         end
         (state == S_INT): begin
            ctrl.pc_write  = 1'b1;
            ctrl.epc_write = 1'b1;
            ctrl.pc_source = PC_VEC;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer: state register, opcode
// dispatch, interrupt entry at boundaries, strobe gating.
module multicycle_control
   import mips_pkg::*;
#(
   parameter int INT_ENABLE = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       interrupt,
   output logic       pcWrite,
   output logic       irWrite,
   output logic       memRead,
   output logic       memWrite,
   output logic       regWrite,
   output logic       epcWrite,
   output logic       iorD,
   output logic       regDst,
   output logic       memtoReg,
   output logic       aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] aluOp,
   output logic [1:0] pcSource,
   output logic [3:0] state,
   output logic       illegal
);

   state_t state_q;
   state_t state_d;
   state_t boundary;
   logic   pending;
   logic   illegal_q;
   logic   bad_op;
   logic   go;
   ctrl_t  ctrl;

   assign boundary = (pending && INT_ENABLE != 0) ? S_INT : S_FETCH;

   always_ff @(posedge clock) begin
      if (reset)
         state_q <= S_FETCH;
      else if (enable)
         state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      bad_op  = 1'b0;
      case (state_q)
         S_FETCH:   state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW,
               OP_SW:    state_d = S_MEMADR;
               OP_RTYPE: state_d = S_EXEC;
               OP_BEQ:   state_d = S_BRANCH;
               OP_J:     state_d = S_JUMP;
               OP_ADDI:  state_d = S_ADDI_EX;
               default: begin
                  state_d = boundary;
                  bad_op  = 1'b1;
               end
            endcase
         end
         S_MEMADR:
            state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   state_d = S_MEMWB;
         S_EXEC:    state_d = S_RWB;
         S_ADDI_EX: state_d = S_ADDI_WB;
         S_MEMWB,
         S_MEMWR,
         S_RWB,
         S_BRANCH,
         S_JUMP,
         S_ADDI_WB: state_d = boundary;
         default:   state_d = S_FETCH;
      endcase
   end

   // a request arriving on the clearing cycle must not be lost
   always_ff @(posedge clock) begin
      if (reset)
         pending <= 1'b0;
      else if (interrupt)
         pending <= 1'b1;
      else if (enable && state_q == S_INT)
         pending <= 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset)
         illegal_q <= 1'b0;
      else if (enable && bad_op)
         illegal_q <= 1'b1;
   end

   mc_output_decode u_dec (
      .state (state_q),
      .ctrl  (ctrl)
   );

   assign go = enable && !reset;

   assign pcWrite  = go && (ctrl.pc_write ||
                            (ctrl.pc_write_cond && zero));
   assign irWrite  = go && ctrl.ir_write;
   assign memRead  = go && ctrl.mem_read;
   assign memWrite = go && ctrl.mem_write;
   assign regWrite = go && ctrl.reg_write;
   assign epcWrite = go && ctrl.epc_write;
   assign iorD     = ctrl.iord;
   assign regDst   = ctrl.reg_dst;
   assign memtoReg = ctrl.memto_reg;
   assign aluSrcA  = ctrl.alu_src_a;
   assign aluSrcB  = ctrl.alu_src_b;
   assign aluOp    = ctrl.alu_op;
   assign pcSource = ctrl.pc_source;
   assign state    = state_q;
   assign illegal  = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios plus random
// instruction streams checked against a per-instruction state model.
module tb_multicycle_control;

   localparam logic [5:0] T_LW   = 6'b100011;
   localparam logic [5:0] T_SW   = 6'b101011;
   localparam logic [5:0] T_RT   = 6'b000000;
   localparam logic [5:0] T_BEQ  = 6'b000100;
   localparam logic [5:0] T_J    = 6'b000010;
   localparam logic [5:0] T_ADDI = 6'b001000;
   localparam bit INT_EN = 1'b1;

   logic       clock = 1'b0;
   logic       reset, enable, zero, interrupt;
   logic [5:0] opcode;
   logic       pcWrite, irWrite, memRead, memWrite;
   logic       regWrite, epcWrite, iorD, regDst;
   logic       memtoReg, aluSrcA, illegal;
   logic [1:0] aluSrcB, aluOp, pcSource;
   logic [3:0] state;

   int  total = 0;
   int  bad = 0;
   int  mw_cnt = 0;
   bit  pend_m = 1'b0;
   bit  ill_m = 1'b0;
   bit  rnd = 1'b0;

   always #5 clock = ~clock;

   multicycle_control #(.INT_ENABLE(1)) dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .opcode    (opcode),
      .zero      (zero),
      .interrupt (interrupt),
      .pcWrite   (pcWrite),
      .irWrite   (irWrite),
      .memRead   (memRead),
      .memWrite  (memWrite),
      .regWrite  (regWrite),
      .epcWrite  (epcWrite),
      .iorD      (iorD),
      .regDst    (regDst),
      .memtoReg  (memtoReg),
      .aluSrcA   (aluSrcA),
      .aluSrcB   (aluSrcB),
      .aluOp     (aluOp),
      .pcSource  (pcSource),
      .state     (state),
      .illegal   (illegal)
   );

   function automatic bit is_legal(input logic [5:0] op);
      return op == T_LW || op == T_SW || op == T_RT ||
             op == T_BEQ || op == T_J || op == T_ADDI;
   endfunction

   // {pcW,irW,mRd,mWr,rW,epcW,iorD,rDst,m2r,srcA,srcB,aluOp,pcSrc}
   function automatic logic [15:0] exp_word(
      input logic [3:0] s, input logic g, input logic z);
      logic pw, iw, mr, mw, rw, ew, io, rd, mt, sa;
      logic [1:0] sb, ao, ps;
      {pw, iw, mr, mw, rw, ew, io, rd, mt, sa} = '0;
      sb = 2'd0; ao = 2'd0; ps = 2'd0;
      case (s)
         4'd0: begin pw = 1; iw = 1; mr = 1; sb = 2'd1; end
         4'd1: sb = 2'd3;
         4'd2, 4'd10: begin sa = 1; sb = 2'd2; end
         4'd3: begin mr = 1; io = 1; end
         4'd4: begin rw = 1; mt = 1; end
         4'd5: begin mw = 1; io = 1; end
         4'd6: begin sa = 1; ao = 2'd2; end
         4'd7: begin rw = 1; rd = 1; end
         4'd8: begin sa = 1; ao = 2'd1; ps = 2'd1; pw = z; end
         4'd9: begin pw = 1; ps = 2'd2; end
         4'd11: rw = 1;
         4'd12: begin pw = 1; ew = 1; ps = 2'd3; end
         default: ;
      endcase
      if (!g) {pw, iw, mr, mw, rw, ew} = '0;
      return {pw, iw, mr, mw, rw, ew, io, rd, mt, sa,
              sb, ao, ps};
   endfunction

   task automatic tick(input logic [3:0] es, input logic [5:0] op,
                       input logic en, input logic intr,
                       input logic z, input logic rst);
      logic [15:0] obs, exw;
      @(negedge clock);
      reset = rst; enable = en; opcode = op;
      interrupt = intr; zero = z;
      #1;
      obs = {pcWrite, irWrite, memRead, memWrite, regWrite,
             epcWrite, iorD, regDst, memtoReg, aluSrcA,
             aluSrcB, aluOp, pcSource};
      exw = exp_word(es, en && !rst, z);
      total++;
      assert (state === es) else begin
         bad++;
         $error("FAIL state obs=%0d exp=%0d", state, es);
      end
      total++;
      assert (obs === exw) else begin
         bad++;
         $error("FAIL ctrl st=%0d obs=%h exp=%h", es, obs, exw);
      end
      total++;
      assert (illegal === ill_m) else begin
         bad++;
         $error("FAIL illegal obs=%b exp=%b", illegal, ill_m);
      end
      if (memWrite) mw_cnt++;
      @(posedge clock);
      if (rst) begin
         pend_m = 1'b0;
         ill_m  = 1'b0;
      end else begin
         if (en && es == 4'd1 && !is_legal(op)) ill_m = 1'b1;
         pend_m = intr || (pend_m && !(en && es == 4'd12));
      end
   endtask

   task automatic run_instr(input logic [5:0] op);
      logic [3:0] seq[$];
      logic en, intr, z, oldp, take;
      take = 1'b0;
      oldp = 1'b0;
      case (op)
         T_LW:    seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
         T_SW:    seq = '{4'd0, 4'd1, 4'd2, 4'd5};
         T_RT:    seq = '{4'd0, 4'd1, 4'd6, 4'd7};
         T_ADDI:  seq = '{4'd0, 4'd1, 4'd10, 4'd11};
         T_BEQ:   seq = '{4'd0, 4'd1, 4'd8};
         T_J:     seq = '{4'd0, 4'd1, 4'd9};
         default: seq = '{4'd0, 4'd1};
      endcase
      foreach (seq[i]) begin
         do begin
            en   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            intr = rnd ? ($urandom_range(0, 11) == 0) : 1'b0;
            z    = 1'($urandom_range(0, 1));
            oldp = pend_m;
            tick(seq[i], (seq[i] == 4'd0) ? 6'($urandom) : op,
                 en, intr, z, 1'b0);
         end while (!en);
         if (i == seq.size() - 1) take = oldp;
      end
      if (take && INT_EN) begin
         do begin
            en   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            intr = rnd ? ($urandom_range(0, 11) == 0) : 1'b0;
            tick(4'd12, 6'($urandom), en, intr, 1'b0, 1'b0);
         end while (!en);
      end
   endtask

   function automatic logic [5:0] pick_op();
      case ($urandom_range(0, 7))
         0: return T_LW;
         1: return T_SW;
         2: return T_RT;
         3: return T_BEQ;
         4: return T_J;
         5: return T_ADDI;
         default: return 6'($urandom);
      endcase
   endfunction

   initial begin
      reset = 1'b1; enable = 1'b1; opcode = '0;
      zero = 1'b0; interrupt = 1'b0;
      repeat (2) @(posedge clock);
      tick(4'd0, T_LW, 1, 0, 0, 1);

      // lw from reset
      run_instr(T_LW);

      // beq taken then not taken
      tick(4'd0, T_RT, 1, 0, 0, 0);
      tick(4'd1, T_BEQ, 1, 0, 0, 0);
      tick(4'd8, T_BEQ, 1, 0, 1, 0);
      tick(4'd0, T_RT, 1, 0, 1, 0);
      tick(4'd1, T_BEQ, 1, 0, 1, 0);
      tick(4'd8, T_BEQ, 1, 0, 0, 0);

      // interrupt pulse during EXEC
      tick(4'd0, T_J, 1, 0, 0, 0);
      tick(4'd1, T_RT, 1, 0, 0, 0);
      tick(4'd6, T_RT, 1, 1, 0, 0);
      tick(4'd7, T_RT, 1, 0, 0, 0);
      tick(4'd12, T_RT, 1, 0, 0, 0);
      run_instr(T_RT);

      // sw with enable 1,0,0,1 in MEMWR
      mw_cnt = 0;
      tick(4'd0, T_SW, 1, 0, 0, 0);
      tick(4'd1, T_SW, 1, 0, 0, 0);
      tick(4'd2, T_SW, 1, 0, 0, 0);
      tick(4'd5, T_SW, 0, 0, 0, 0);
      tick(4'd5, T_SW, 0, 0, 0, 0);
      tick(4'd5, T_SW, 1, 0, 0, 0);
      total++;
      assert (mw_cnt == 1) else begin
         bad++;
         $error("FAIL sw_once obs=%0d exp=1", mw_cnt);
      end

      // illegal opcode, sticky, cleared by reset
      tick(4'd0, T_LW, 1, 0, 0, 0);
      tick(4'd1, 6'h3f, 1, 0, 0, 0);
      run_instr(T_ADDI);
      tick(4'd0, T_LW, 1, 0, 0, 1);
      run_instr(T_J);

      // reset in MEMRD with an interrupt pending
      tick(4'd0, T_LW, 1, 0, 0, 0);
      tick(4'd1, T_LW, 1, 0, 0, 0);
      tick(4'd2, T_LW, 1, 1, 0, 0);
      tick(4'd3, T_LW, 1, 0, 0, 1);
      run_instr(T_RT);
      run_instr(T_BEQ);

      // random stream with stalls and interrupts
      rnd = 1'b1;
      repeat (150) run_instr(pick_op());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
